clk_sched: RTL and testbench
============================

CLK_SCHED -- requirements
Module: clk_sched

Interface
REQ-001 Parameter DEB_CYCLES, default 16, number of consecutive cycles step_btn must be stable high before a step is accepted.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 reserved (treated as HALT).
REQ-005 div_sel  input  5  RUN-mode period select; enable period = 2^div_sel clk cycles.
REQ-006 step_btn  input  1  asynchronous single-step request from a push button.
REQ-007 cpu_en  output  1  registered single-cycle clock-enable pulse for the downstream datapath.
REQ-008 tick_cnt  output  32  count of cpu_en pulses issued since reset.
REQ-009 state  output  2  current FSM state: 00 HALT, 01 RUN, 10 STEP_WAIT, 11 STEP_FIRE.

Function
REQ-010 The FSM SHALL have states HALT, RUN, STEP_WAIT and STEP_FIRE, encoded as on the state output.
REQ-011 mode SHALL be sampled every cycle; mode 00 or 11 SHALL force HALT on the next edge from any state.
REQ-012 mode 01 SHALL move any state to RUN on the next edge; mode 10 SHALL move HALT or RUN to STEP_WAIT on the next edge.
REQ-013 STEP_FIRE SHALL last exactly one cycle and return to STEP_WAIT (or HALT/RUN if mode changed).
REQ-014 In RUN, a prescaler counter SHALL count 0 .. 2^div_sel-1 and wrap; cpu_en SHALL be 1 in the cycle after the prescaler reaches 2^div_sel-1.
REQ-015 div_sel = 0 SHALL give cpu_en = 1 on every cycle while in RUN.
REQ-016 The prescaler SHALL clear to 0 on entry to RUN and whenever div_sel differs from its value in the previous cycle.
REQ-017 cpu_en SHALL be 1 for the single cycle the FSM is in STEP_FIRE; cpu_en SHALL be 0 in HALT and STEP_WAIT.
REQ-018 step_btn SHALL pass through a two-flop synchronizer before any other use.
REQ-019 A step SHALL be accepted only on a rising edge of the qualified button signal; a held button SHALL produce exactly one STEP_FIRE.
REQ-020 A step edge occurring outside STEP_WAIT SHALL be discarded, not queued.
REQ-021 tick_cnt SHALL increment by 1 in every cycle cpu_en = 1, and wrap from 0xFFFFFFFF to 0.
REQ-022 A mode change during STEP_FIRE SHALL not suppress the already-registered cpu_en pulse.

Reset
REQ-023 With reset = 0 at a rising edge: state = HALT, cpu_en = 0, tick_cnt = 0, prescaler = 0, synchronizer and debounce registers = 0.
REQ-024 Reset SHALL override all other inputs, including mid-RUN and mid-debounce; the first step after reset requires a fresh button rising edge.

Configuration
REQ-025 Macro CLK_SCHED_DEBOUNCE_EN SHALL select debounce logic.
REQ-026 With CLK_SCHED_DEBOUNCE_EN defined: the qualified button SHALL go high only after synchronized step_btn is 1 for DEB_CYCLES consecutive cycles, and low as soon as synchronized step_btn is 0; cpu_en rises DEB_CYCLES+3 edges after step_btn is first sampled high.
REQ-027 Without CLK_SCHED_DEBOUNCE_EN: qualified button = synchronized step_btn; cpu_en rises 3 edges after step_btn is first sampled high; DEB_CYCLES is unused.

Verification
REQ-028 reset=0 for 2 cycles with mode=01 -> state=00, cpu_en=0, tick_cnt=0 throughout.
REQ-029 mode=01, div_sel=2 for 40 cycles -> cpu_en pulses every 4th cycle, exactly 1 cycle wide, tick_cnt=10 (+/-1 at window edge).
REQ-030 mode=10, macro undefined, step_btn held high 20 cycles -> exactly one cpu_en pulse 3 edges after press, tick_cnt=1, state returns to 10.
REQ-031 mode=10, macro defined, DEB_CYCLES=16, step_btn bounces 1/0 every 3 cycles then holds high -> single cpu_en 19 edges after the stable-high start.
REQ-032 RUN with div_sel=3, switch div_sel to 1 mid-count -> prescaler restarts, next cpu_en 2 cycles later; then mode=00 -> cpu_en stays 0, tick_cnt frozen.
REQ-033 Force tick_cnt near wrap (0xFFFFFFFE), RUN div_sel=0 for 3 cycles -> tick_cnt reads 0xFFFFFFFF, 0x00000000, 0x00000001.

Source files
------------

// File: rtl/clk_sched.sv
// Clock-enable scheduler: HALT, free-running RUN prescaler and single-step from a push button.
// Define CLK_SCHED_DEBOUNCE_EN to qualify step_btn with a DEB_CYCLES-long stability filter.
module clk_sched #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [4:0]  div_sel,
    input  logic        step_btn,
    output logic        cpu_en,
    output logic [31:0] tick_cnt,
    output logic [1:0]  state
);
    localparam int unsigned PRESC_W = 32;

    typedef enum logic [1:0] {
        HALT      = 2'b00,
        RUN       = 2'b01,
        STEP_WAIT = 2'b10,
        STEP_FIRE = 2'b11
    } state_t;

    state_t               st;
    logic                 sync1;
    logic                 sync2;
    logic                 qual;
    logic                 qual_d;
    logic [4:0]           div_q;
    logic [PRESC_W-1:0]   presc;
    logic [PRESC_W-1:0]   presc_max;
    logic                 div_chg;
    logic                 step_edge;
    logic                 run_fire;

    if (DEB_CYCLES == 0) begin : g_deb_check
        $error("clk_sched: DEB_CYCLES must be at least 1");
    end

    // Button synchronizer, qualified-level history and previous div_sel
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            qual_d <= 1'b0;
            div_q  <= 5'd0;
        end else begin
            sync1  <= step_btn;
            sync2  <= sync1;
            qual_d <= qual;
            div_q  <= div_sel;
        end
    end

`ifdef CLK_SCHED_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt;

    // Qualified level rises after DEB_CYCLES consecutive high samples, drops on any low
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb_cnt <= '0;
            qual    <= 1'b0;
        end else if (!sync2) begin
            deb_cnt <= '0;
            qual    <= 1'b0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            qual    <= 1'b1;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end
`else
    assign qual = sync2;
`endif

    always_comb begin
        presc_max = ~({PRESC_W{1'b1}} << div_sel);
        div_chg   = (div_sel != div_q);
        step_edge = qual & ~qual_d;
        // div_sel 0 pulses on every RUN cycle, including the entry cycle
        run_fire  = (div_sel == 5'd0) ||
                    ((st == RUN) && !div_chg && (presc == presc_max));
    end

    // Scheduler FSM with registered enable pulse and tick counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            st       <= HALT;
            cpu_en   <= 1'b0;
            tick_cnt <= 32'd0;
            presc    <= '0;
        end else begin
            cpu_en <= 1'b0;
            presc  <= '0;
            unique case (mode)
                2'b01: begin
                    st <= RUN;
                    if ((st == RUN) && !div_chg && (presc != presc_max)) begin
                        presc <= presc + PRESC_W'(1);
                    end
                    if (run_fire) begin
                        cpu_en   <= 1'b1;
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                2'b10: begin
                    if (st == STEP_WAIT) begin
                        if (step_edge) begin
                            st       <= STEP_FIRE;
                            cpu_en   <= 1'b1;
                            tick_cnt <= tick_cnt + 32'd1;
                        end
                    end else begin
                        st <= STEP_WAIT;
                    end
                end
                default: st <= HALT;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_clk_sched.sv
// Self-checking bench for clk_sched: cycle model feeds a scoreboard, plus directed latency,
// period, wrap and discard checks.
module tb_clk_sched;
    localparam int unsigned DEB = 16;
`ifdef CLK_SCHED_DEBOUNCE_EN
    localparam int unsigned HW      = DEB + 3;
    localparam int unsigned EXP_LAT = DEB + 3;
`else
    localparam int unsigned HW      = 3;
    localparam int unsigned EXP_LAT = 3;
`endif

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic [31:0] tick;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic [4:0]  div_sel;
    logic        step_btn;
    logic        cpu_en;
    logic [31:0] tick_cnt;
    logic [1:0]  state;

    sb_t         sb[$];
    sb_t         got_item;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [HW-1:0] m_hist;
    logic [1:0]    m_state;
    logic          m_en;
    logic [31:0]   m_tick;
    logic [63:0]   m_age;
    logic [4:0]    m_div_prev;

    clk_sched #(.DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .div_sel  (div_sel),
        .step_btn (step_btn),
        .cpu_en   (cpu_en),
        .tick_cnt (tick_cnt),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after the coming edge, from the inputs currently driven
    task automatic model_step();
        logic       q_now, q_prev, btn_edge, chg;
        logic [1:0] nxt;
        logic [63:0] per;
        if (!reset) begin
            m_hist = '0; m_state = 2'b00; m_en = 1'b0; m_tick = 32'd0;
            m_age = 64'd0; m_div_prev = 5'd0;
        end else begin
`ifdef CLK_SCHED_DEBOUNCE_EN
            q_now  = &m_hist[DEB+1:2];
            q_prev = &m_hist[DEB+2:3];
`else
            q_now  = m_hist[1];
            q_prev = m_hist[2];
`endif
            btn_edge = q_now & ~q_prev;
            chg = (div_sel != m_div_prev);
            per = 64'd1 << div_sel;
            case (mode)
                2'b01:   nxt = 2'b01;
                2'b10:   nxt = (m_state == 2'b10 && btn_edge) ? 2'b11 : 2'b10;
                default: nxt = 2'b00;
            endcase
            m_en = (nxt == 2'b11) ||
                   ((nxt == 2'b01) && ((div_sel == 5'd0) ||
                    ((m_state == 2'b01) && !chg && ((m_age % per) == per - 64'd1))));
            m_age = ((nxt == 2'b01) && (m_state == 2'b01) && !chg) ? m_age + 64'd1 : 64'd0;
            m_tick = m_tick + 32'(m_en);
            m_div_prev = div_sel;
            m_state = nxt;
            m_hist = {m_hist[HW-2:0], step_btn};
        end
    endtask

    task automatic cyc();
        model_step();
        sb.push_back('{st: m_state, en: m_en, tick: m_tick});
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            got_item = sb.pop_front();
            chk("sb_state", 32'(state), 32'(got_item.st));
            chk("sb_cpu_en", 32'(cpu_en), 32'(got_item.en));
            chk("sb_tick", tick_cnt, got_item.tick);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, lat, found;
        logic [31:0] t_hold;
        reset = 1'b0; mode = 2'b01; div_sel = 5'd0; step_btn = 1'b0;
        @(negedge clk);
        repeat (2) cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_tick", tick_cnt, 32'd0);

        // RUN with a period of 4
        reset = 1'b1; mode = 2'b01; div_sel = 5'd2;
        n = 0; last = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cpu_en) begin
                if (last >= 0) chk("run_gap", 32'(i - last), 32'd4);
                last = i; n++;
            end
        end
        chk("run_count_in_range", 32'((n >= 9) && (n <= 11)), 32'd1);

        mode = 2'b00;
        repeat (3) cyc();

        // Held button gives one step at a fixed latency
        mode = 2'b10;
        repeat (3) cyc();
        step_btn = 1'b1; lat = 0; n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cpu_en) begin
                n++;
                if (lat == 0) lat = i;
            end
        end
        chk("step_latency", 32'(lat), 32'(EXP_LAT));
        chk("step_pulses", 32'(n), 32'd1);
        chk("step_state", 32'(state), 32'd2);
        step_btn = 1'b0;
        repeat (DEB + 4) cyc();

        // Bouncing press followed by a stable hold
        for (int r = 0; r < 4; r++) begin
            step_btn = 1'b1; repeat (3) cyc();
            step_btn = 1'b0; repeat (3) cyc();
        end
        step_btn = 1'b1; lat = 0; n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (cpu_en) begin
                n++;
                if (lat == 0) lat = i;
            end
        end
        chk("bounce_latency", 32'(lat), 32'(EXP_LAT));
        chk("bounce_pulses", 32'(n), 32'd1);
        step_btn = 1'b0;
        repeat (DEB + 4) cyc();

        // Press that rises while halted is discarded
        mode = 2'b00; step_btn = 1'b1;
        repeat (DEB + 8) cyc();
        mode = 2'b10; n = 0;
        for (int i = 0; i < DEB + 8; i++) begin
            cyc();
            if (cpu_en) n++;
        end
        chk("discard_pulses", 32'(n), 32'd0);
        chk("discard_state", 32'(state), 32'd2);
        step_btn = 1'b0;
        repeat (DEB + 4) cyc();

        // Mode change while in STEP_FIRE keeps the pulse
        step_btn = 1'b1;
        for (int i = 0; i < 50 && state != 2'b11; i++) cyc();
        chk("fire_reached", 32'(state), 32'd3);
        mode = 2'b01; div_sel = 5'd1;
        chk("fire_en_kept", 32'(cpu_en), 32'd1);
        cyc();
        chk("fire_to_run", 32'(state), 32'd1);
        step_btn = 1'b0;

        // div_sel change restarts the prescaler
        div_sel = 5'd3;
        repeat (5) cyc();
        div_sel = 5'd1;
        cyc();
        chk("divchg_en0", 32'(cpu_en), 32'd0);
        found = 0;
        for (int i = 1; i <= 10 && found == 0; i++) begin
            cyc();
            if (cpu_en) found = i;
        end
        chk("divchg_latency", 32'(found), 32'd2);

        mode = 2'b00;
        cyc();
        t_hold = m_tick; n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (cpu_en) n++;
        end
        chk("halt_no_pulse", 32'(n), 32'd0);
        chk("halt_tick_frozen", tick_cnt, t_hold);

        // Counter wrap
        force dut.tick_cnt = 32'hFFFF_FFFE;
        m_tick = 32'hFFFF_FFFE;
        #1;
        release dut.tick_cnt;
        mode = 2'b01; div_sel = 5'd0;
        cyc(); chk("wrap_0", tick_cnt, 32'hFFFF_FFFF);
        cyc(); chk("wrap_1", tick_cnt, 32'h0000_0000);
        cyc(); chk("wrap_2", tick_cnt, 32'h0000_0001);

        // Reset mid-RUN
        div_sel = 5'd1;
        repeat (5) cyc();
        reset = 1'b0;
        repeat (2) cyc();
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_tick", tick_cnt, 32'd0);
        reset = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) div_sel = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            cyc();
        end

        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
